// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: hall six-step sequence, direction encoding and default gate length.
// Used by the speed meter and the commutation logic.
package bldc_pkg;

  localparam int unsigned GateCyclesDefault = 50000;

  typedef logic [2:0] hall_code_t;

  // Forward rotation visits HallS0 -> HallS5 and wraps back to HallS0
  localparam hall_code_t HallS0 = 3'b001;
  localparam hall_code_t HallS1 = 3'b011;
  localparam hall_code_t HallS2 = 3'b010;
  localparam hall_code_t HallS3 = 3'b110;
  localparam hall_code_t HallS4 = 3'b100;
  localparam hall_code_t HallS5 = 3'b101;

  typedef enum logic {
    DirFwd = 1'b0,
    DirRev = 1'b1
  } dir_e;

  function automatic logic hall_legal(input hall_code_t code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  function automatic hall_code_t hall_next(input hall_code_t code);
    hall_code_t res;
    case (code)
      HallS0:  res = HallS1;
      HallS1:  res = HallS2;
      HallS2:  res = HallS3;
      HallS3:  res = HallS4;
      HallS4:  res = HallS5;
      HallS5:  res = HallS0;
      default: res = code;
    endcase
    return res;
  endfunction

  function automatic hall_code_t hall_prev(input hall_code_t code);
    hall_code_t res;
    case (code)
      HallS0:  res = HallS5;
      HallS1:  res = HallS0;
      HallS2:  res = HallS1;
      HallS3:  res = HallS2;
      HallS4:  res = HallS3;
      HallS5:  res = HallS4;
      default: res = code;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] sat_u8(input logic [8:0] value);
    return (value > 9'd255) ? 8'hff : value[7:0];
  endfunction

endpackage

// File: rtl/hall_decode.sv
// Hall input synchronizer and step decoder: compares synchronized code hs against its
// previous value hp and flags forward/reverse steps or illegal codes/transitions.
module hall_decode
  import bldc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall,
  output logic       fwd_edge,
  output logic       rev_edge,
  output logic       bad_code
);

  hall_code_t sync1;
  hall_code_t hs;
  hall_code_t hp;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      hs    <= '0;
      hp    <= '0;
    end else begin
      sync1 <= hall;
      hs    <= sync1;
      hp    <= hs;
    end
  end

  // An illegal hp means there is no valid reference: the next legal code only reloads it.
  always_comb begin
    fwd_edge = 1'b0;
    rev_edge = 1'b0;
    bad_code = 1'b0;
    if (hs != hp) begin
      if (!hall_legal(hs)) begin
        bad_code = 1'b1;
      end else if (hall_legal(hp)) begin
        if (hs == hall_next(hp)) begin
          fwd_edge = 1'b1;
        end else if (hs == hall_prev(hp)) begin
          rev_edge = 1'b1;
        end else begin
          bad_code = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hall_speed_meter.sv
// Hall-sensor speed meter: counts valid hall edges per gate window, reports direction,
// hall errors and a stall flag after consecutive empty windows.
module hall_speed_meter
  import bldc_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = GateCyclesDefault,
  parameter int unsigned STALL_WINDOWS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [2:0] hall,
  output logic [7:0] current_vel,
  output logic       vel_valid,
  output logic       dir,
  output logic       hall_err,
  output logic       stall
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned ZeroW = (STALL_WINDOWS > 0) ? $clog2(STALL_WINDOWS + 1) : 1;
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [ZeroW-1:0] ZeroMax  = ZeroW'(STALL_WINDOWS);

  logic fwd_edge;
  logic rev_edge;
  logic bad_code;

  hall_decode u_hall_decode (
    .clk      (CLK),
    .rst      (RST),
    .hall     (hall),
    .fwd_edge (fwd_edge),
    .rev_edge (rev_edge),
    .bad_code (bad_code)
  );

  logic [GateW-1:0] gate_cnt;
  logic [8:0]       edge_cnt;
  logic [ZeroW-1:0] zero_cnt;

  logic             valid_edge;
  logic             terminal;
  logic [8:0]       edge_inc;
  logic [ZeroW-1:0] zero_next;

  always_comb begin
    valid_edge = fwd_edge | rev_edge;
    terminal   = (gate_cnt == GateLast);
    edge_inc   = (edge_cnt == 9'd511) ? edge_cnt : edge_cnt + 9'd1;
    if (edge_cnt != '0) begin
      zero_next = '0;
    end else if (zero_cnt == ZeroMax) begin
      zero_next = zero_cnt;
    end else begin
      zero_next = zero_cnt + ZeroW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      zero_cnt    <= '0;
      current_vel <= '0;
      vel_valid   <= 1'b0;
      dir         <= DirFwd;
      hall_err    <= 1'b0;
      stall       <= 1'b0;
    end else if (!EN) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      vel_valid <= 1'b0;
      hall_err  <= 1'b0;
    end else begin
      vel_valid <= terminal;
      hall_err  <= bad_code;
      if (valid_edge) begin
        dir <= rev_edge ? DirRev : DirFwd;
      end
      if (terminal) begin
        gate_cnt    <= '0;
        current_vel <= sat_u8(edge_cnt);
        // An edge on the terminal cycle belongs to the window that starts now
        edge_cnt    <= {8'd0, valid_edge};
        zero_cnt    <= zero_next;
      end else begin
        gate_cnt <= gate_cnt + GateW'(1);
        if (valid_edge) begin
          edge_cnt <= edge_inc;
        end
      end
      if (valid_edge) begin
        stall <= 1'b0;
      end else if (terminal && (zero_next == ZeroMax)) begin
        stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hall_speed_meter.sv
// Directed bench for hall_speed_meter: short-gate instance for most cases, long-gate
// instance for the velocity saturation case.
module tb_hall_speed_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       en_b = 1'b0;
  logic [2:0] hall = 3'b001;
  logic [2:0] hall_b = 3'b001;

  logic [7:0] vel, vel_b;
  logic       vv, vv_b, dir, dir_b, err, err_b, stall, stall_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int err_b_cnt = 0;
  int vv_cnt = 0;
  int en_cyc, e0, v0, n;

  logic [2:0] fwd_seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  always #5 clk = ~clk;

  hall_speed_meter #(
    .GATE_CYCLES   (100),
    .STALL_WINDOWS (4)
  ) u_dut (
    .CLK         (clk),
    .RST         (rst),
    .EN          (en),
    .hall        (hall),
    .current_vel (vel),
    .vel_valid   (vv),
    .dir         (dir),
    .hall_err    (err),
    .stall       (stall)
  );

  hall_speed_meter #(
    .GATE_CYCLES   (400),
    .STALL_WINDOWS (4)
  ) u_big (
    .CLK         (clk),
    .RST         (rst),
    .EN          (en_b),
    .hall        (hall_b),
    .current_vel (vel_b),
    .vel_valid   (vv_b),
    .dir         (dir_b),
    .hall_err    (err_b),
    .stall       (stall_b)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (err_b) err_b_cnt++;
    if (vv) vv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!vv && k < limit);
    check({tag, "_valid"}, vv, 1);
  endtask

  // Reset both instances with hall parked on a legal code, then let the reference load.
  task automatic start(input logic [2:0] code);
    en   = 1'b0;
    rst  = 1'b1;
    hall = code;
    tick(3);
    rst = 1'b0;
    tick(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Five forward steps in one window
    start(3'b001);
    en = 1'b1;
    en_cyc = cyc;
    e0 = err_cnt;
    for (int i = 1; i < 6; i++) begin
      tick(5);
      hall = fwd_seq[i];
    end
    wait_valid("t1", 200);
    check("t1_latency", cyc - en_cyc, 100);
    check("t1_vel", vel, 5);
    check("t1_dir", dir, 0);
    check("t1_no_err", err_cnt - e0, 0);
    tick(1);
    check("t1_pulse_width", vv, 0);

    // Reverse steps, direction latency
    start(3'b001);
    en = 1'b1;
    hall = 3'b101;
    tick(2);
    check("t2_dir_early", dir, 0);
    tick(1);
    check("t2_dir_3cyc", dir, 1);
    tick(5);
    hall = 3'b100;
    wait_valid("t2", 200);
    check("t2_vel", vel, 2);
    check("t2_dir_end", dir, 1);
    rst = 1'b1;
    tick(1);
    check("reset_outputs", {vel, vv, dir, err, stall}, 0);

    // Skipped step, illegal code, reload after illegal
    start(3'b001);
    en = 1'b1;
    e0 = err_cnt;
    hall = 3'b010;
    tick(2);
    check("t3_err_early", err, 0);
    tick(1);
    check("t3_err_skip", err, 1);
    tick(1);
    check("t3_err_pulse", err, 0);
    hall = 3'b111;
    tick(5);
    hall = 3'b011;
    tick(5);
    wait_valid("t3", 200);
    check("t3_vel", vel, 0);
    check("t3_err_count", err_cnt - e0, 2);
    check("t3_dir", dir, 0);

    // 300 forward edges in one long window saturates the 8-bit output
    start(3'b001);
    en_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      hall_b = fwd_seq[(i + 1) % 6];
      tick(1);
    end
    n = 0;
    while (!vv_b && n < 200) begin
      tick(1);
      n++;
    end
    check("t4_valid", vv_b, 1);
    check("t4_vel_sat", vel_b, 255);
    check("t4_dir", dir_b, 0);
    check("t4_no_err", err_b_cnt, 0);
    check("t4_no_stall", stall_b, 0);
    en_b = 1'b0;

    // Stall after four empty windows, cleared by one edge
    start(3'b001);
    en = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_valid("t5", 150);
      if (w == 3) check("t5_stall_w3", stall, 0);
    end
    check("t5_stall_w4", stall, 1);
    check("t5_vel", vel, 0);
    tick(1);
    hall = 3'b011;
    tick(2);
    check("t5_stall_held", stall, 1);
    tick(1);
    check("t5_stall_clear", stall, 0);

    // Reset mid-window discards the partial count
    start(3'b001);
    en = 1'b1;
    tick(5);
    hall = 3'b011;
    tick(5);
    hall = 3'b010;
    wait_valid("t6a", 200);
    check("t6_vel_first", vel, 2);
    tick(5);
    hall = 3'b110;
    tick(5);
    hall = 3'b100;
    tick(5);
    hall = 3'b101;
    tick(35);
    rst = 1'b1;
    v0 = vv_cnt;
    tick(1);
    rst = 1'b0;
    check("t6_vel_rst", vel, 0);
    tick(60);
    check("t6_no_valid", vv_cnt - v0, 0);
    wait_valid("t6b", 150);
    check("t6_vel_after_rst", vel, 0);

    // Hall moves while disabled; re-enable must not produce an edge
    en = 1'b0;
    tick(3);
    hall = 3'b100;
    tick(10);
    check("t6_dir_held", dir, 0);
    en = 1'b1;
    e0 = err_cnt;
    wait_valid("t6c", 150);
    check("t6_vel_reenable", vel, 0);
    check("t6_dir_reenable", dir, 0);
    check("t6_no_err", err_cnt - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
